// File: rtl/ps2_keyboard_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : ps2_pkg                                                   |
// | Purpose  : Shared types and constants for the PS/2 keyboard receiver |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_E0 = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_E1 = 8'hE1;
  localparam logic [7:0] PS2_BREAK_F0  = 8'hF0;

  localparam int PS2_FRAME_BITS = 11;
  // Start, parity and stop surround the data byte.
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PREFIX_E0) || (b == PS2_PREFIX_E1) || (b == PS2_BREAK_F0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_receiver_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_input_conditioner                                     |
// | Purpose  : Synchronises PS/2 lines, debounces clock, flags fall edge |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ps2_input_conditioner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [4:0] debounce_time,
  input  logic       synchronizer_enable,
  output logic       clk_filtered,
  output logic       clk_fall,
  output logic       data_sync
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic [4:0] r_db_cnt;
  logic       r_clk_filt;
  logic       r_clk_filt_prev;
  logic       w_clk_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_data_sync <= {r_data_sync[0], ps2_data_in};
    end
  end

  // Depth is chosen every cycle by tapping either stage.
  assign w_clk_sync = synchronizer_enable ? r_clk_sync[1]  : r_clk_sync[0];
  assign data_sync  = synchronizer_enable ? r_data_sync[1] : r_data_sync[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt        <= 5'd0;
      r_clk_filt      <= 1'b1;
      r_clk_filt_prev <= 1'b1;
    end else begin
      r_clk_filt_prev <= r_clk_filt;
      if (w_clk_sync == r_clk_filt) begin
        r_db_cnt <= 5'd0;
      end else if (r_db_cnt == debounce_time) begin
        r_clk_filt <= w_clk_sync;
        r_db_cnt   <= 5'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 5'd1;
      end
    end
  end

  assign clk_filtered = r_clk_filt;
  assign clk_fall     = r_clk_filt_prev & ~r_clk_filt;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_keyboard_receiver                                     |
// | Purpose  : PS/2 frame receiver and multi-byte scan code assembler.   |
// |            Define PS2_RX_TIMEOUT_EN to abandon stalled frames.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ps2_keyboard_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    input  logic [4:0]  debounce_time,
    input  logic        synchronizer_enable,
    output logic [23:0] key_code,
    output logic        key_valid,
    output logic        frame_error,
    output logic        parity_error
);

    logic       w_clk_filt;
    logic       w_clk_fall;
    logic       w_data;
    logic       w_edge;
    logic       w_parity_ok;

    ps2_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic [15:0] r_prefix;
    logic [23:0] r_key_code;
    logic        r_key_valid;
    logic        r_frame_error;
    logic        r_parity_error;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_idle_cnt;
`endif

    ps2_input_conditioner u_cond (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ps2_clk_in          (ps2_clk_in),
        .ps2_data_in         (ps2_data_in),
        .debounce_time       (debounce_time),
        .synchronizer_enable (synchronizer_enable),
        .clk_filtered        (w_clk_filt),
        .clk_fall            (w_clk_fall),
        .data_sync           (w_data)
    );

    assign w_edge      = w_clk_fall & ~w_clk_filt;
    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign w_parity_ok = ^{r_shift, r_parity};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= 3'd0;
            r_shift        <= 8'd0;
            r_parity       <= 1'b0;
            r_prefix       <= 16'd0;
            r_key_code     <= 24'd0;
            r_key_valid    <= 1'b0;
            r_frame_error  <= 1'b0;
            r_parity_error <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            r_idle_cnt     <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            if (w_edge || r_state == ST_IDLE) r_idle_cnt <= '0;
            else                              r_idle_cnt <= r_idle_cnt + 1'b1;
`endif
            if (w_edge) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_frame_error  <= 1'b1;
                            r_parity_error <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state        <= ST_IDLE;
                        r_frame_error  <= ~w_data;
                        r_parity_error <= ~w_parity_ok;
                        if (!w_data || !w_parity_ok) begin
                            r_prefix <= 16'd0;
                        end else if (is_prefix(r_shift)) begin
                            r_prefix <= {r_prefix[7:0], r_shift};
                        end else begin
                            r_key_code  <= {r_prefix, r_shift};
                            r_prefix    <= 16'd0;
                            r_key_valid <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
`ifdef PS2_RX_TIMEOUT_EN
            else if (r_state != ST_IDLE && r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
                r_state        <= ST_IDLE;
                r_frame_error  <= 1'b1;
                r_parity_error <= 1'b0;
                r_prefix       <= 16'd0;
            end
`endif
        end
    end

    assign key_code     = r_key_code;
    assign key_valid    = r_key_valid;
    assign frame_error  = r_frame_error;
    assign parity_error = r_parity_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ps2_keyboard_receiver                                  |
// | Purpose  : Randomised self-checking bench against a scan code model  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_ps2_keyboard_receiver;

    localparam int c_CLK_HALF = 50;    // 100-unit system clock
    localparam int c_BIT_Q    = 2500;  // quarter of a 10000-unit PS/2 bit

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [4:0]  debounce_time = 5'd4;
    logic        synchronizer_enable = 1'b1;
    logic [23:0] key_code;
    logic        key_valid;
    logic        frame_error;
    logic        parity_error;

    int          n_tests = 0;
    int          n_fail = 0;
    int          valid_seen = 0;

    logic [7:0]  m_pfx[$];
    logic [23:0] m_code = 24'd0;
    logic        m_fe = 1'b0;
    logic        m_pe = 1'b0;

    ps2_keyboard_receiver #(.TIMEOUT_CYCLES(100)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ps2_clk_in          (ps2_clk_in),
        .ps2_data_in         (ps2_data_in),
        .debounce_time       (debounce_time),
        .synchronizer_enable (synchronizer_enable),
        .key_code            (key_code),
        .key_valid           (key_valid),
        .frame_error         (frame_error),
        .parity_error        (parity_error)
    );

    always #(c_CLK_HALF) clk = ~clk;

    always @(negedge clk) if (key_valid) valid_seen++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data_in = b;
        #(c_BIT_Q);
        ps2_clk_in = 1'b0;
        #(2 * c_BIT_Q);
        ps2_clk_in = 1'b1;
        #(c_BIT_Q);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2_data_in = 1'b1;
        #(4 * c_BIT_Q);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    // Reference: a frame is good when the stop bit is 1 and data+parity carries an odd count of ones.
    function automatic int model_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [31:0] code;
        logic        odd_ok;
        odd_ok = ($countones({d, par}) % 2 == 1);
        m_fe = !stop;
        m_pe = !odd_ok;
        if (!stop || !odd_ok) begin
            m_pfx.delete();
            return 0;
        end
        if (d == 8'hE0 || d == 8'hE1 || d == 8'hF0) begin
            m_pfx.push_back(d);
            if (m_pfx.size() > 2) void'(m_pfx.pop_front());
            return 0;
        end
        code = 0;
        foreach (m_pfx[i]) code = (code << 8) | 32'(m_pfx[i]);
        code = (code << 8) | 32'(d);
        m_code = code[23:0];
        m_pfx.delete();
        return 1;
    endfunction

    task automatic check_outputs(input string tag, input int pulses_exp, input int base);
        @(negedge clk);
        check_eq({tag, ".code"}, 32'(key_code), 32'(m_code));
        check_eq({tag, ".valid_pulses"}, 32'(valid_seen - base), 32'(pulses_exp));
        check_eq({tag, ".frame_err"}, 32'(frame_error), 32'(m_fe));
        check_eq({tag, ".parity_err"}, 32'(parity_error), 32'(m_pe));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop);
        int base;
        int pulses;
        base = valid_seen;
        send_frame(d, par, stop);
        pulses = model_frame(d, par, stop);
        check_outputs(tag, pulses, base);
    endtask

    // Clock pulse aligned to clk, n system cycles low, with data held at d.
    task automatic glitch(input int n, input logic d);
        ps2_data_in = d;
        repeat (4) @(posedge clk);
        #1 ps2_clk_in = 1'b0;
        repeat (n) @(posedge clk);
        #1 ps2_clk_in = 1'b1;
        repeat (30) @(posedge clk);
        ps2_data_in = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int base;
        logic [7:0] b;
        logic p;
        logic s;

        repeat (3) @(negedge clk);
        check_eq("reset.code", 32'(key_code), 32'h0);
        check_eq("reset.valid", 32'(key_valid), 32'h0);
        check_eq("reset.frame_err", 32'(frame_error), 32'h0);
        check_eq("reset.parity_err", 32'(parity_error), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_frame("good_1c", 8'h1C, 1'b0, 1'b1);
        run_frame("pfx_e0", 8'hE0, good_par(8'hE0), 1'b1);
        run_frame("pfx_f0", 8'hF0, good_par(8'hF0), 1'b1);
        run_frame("code_74", 8'h74, good_par(8'h74), 1'b1);
        run_frame("bad_par_1c", 8'h1C, 1'b1, 1'b1);
        run_frame("good_32", 8'h32, good_par(8'h32), 1'b1);
        run_frame("pfx_e0b", 8'hE0, good_par(8'hE0), 1'b1);
        run_frame("bad_stop", 8'h11, good_par(8'h11), 1'b0);
        run_frame("good_29", 8'h29, good_par(8'h29), 1'b1);
        run_frame("three_e0", 8'hE0, good_par(8'hE0), 1'b1);
        run_frame("three_e1", 8'hE1, good_par(8'hE1), 1'b1);
        run_frame("three_f0", 8'hF0, good_par(8'hF0), 1'b1);
        run_frame("three_7a", 8'h7A, good_par(8'h7A), 1'b1);

        // Short glitches must not be seen, a longer one is one sampled edge.
        base = valid_seen;
        glitch(3, 1'b0);
        glitch(3, 1'b1);
        check_outputs("glitch3", 0, base);
        run_frame("after_glitch", 8'h1C, 1'b0, 1'b1);
        base = valid_seen;
        glitch(6, 1'b1);
        m_fe = 1'b1;
        m_pe = 1'b0;
        check_outputs("glitch6_idle_edge", 0, base);
        run_frame("after_glitch6", 8'h5A, good_par(8'h5A), 1'b1);

        // Asynchronous reset in the middle of a frame discards everything.
        run_frame("pre_rst_e0", 8'hE0, good_par(8'hE0), 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        #(c_BIT_Q / 3) rst_n = 1'b0;
        m_pfx.delete();
        m_code = 24'd0;
        m_fe = 1'b0;
        m_pe = 1'b0;
        base = valid_seen;
        check_outputs("mid_rst", 0, base);
        ps2_data_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame("post_rst_29", 8'h29, good_par(8'h29), 1'b1);

`ifdef PS2_RX_TIMEOUT_EN
        base = valid_seen;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (250) @(posedge clk);
        m_fe = 1'b1;
        m_pe = 1'b0;
        m_pfx.delete();
        check_outputs("timeout", 0, base);
        run_frame("after_timeout", 8'h1C, 1'b0, 1'b1);
`endif

        for (int n = 0; n < 30; n++) begin
            synchronizer_enable = 1'($urandom_range(0, 1));
            debounce_time = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 2))
                    0:       b = 8'hE0;
                    1:       b = 8'hE1;
                    default: b = 8'hF0;
                endcase
            end else begin
                b = 8'($urandom_range(0, 255));
            end
            p = good_par(b);
            if ($urandom_range(0, 9) == 0) p = ~p;
            s = ($urandom_range(0, 9) != 0);
            run_frame("rand", b, p, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
